can_field_sequencer: RTL and testbench
======================================

# can_field_sequencer

Frame-position controller for the CAN decoder. It tracks the current field of a CAN 2.0 frame on each sample-point strobe, using destuffed receive bits. It drives the active-low field-window flags consumed by the per-field error checkers (EOF, CRC delimiter, ACK) and captures the header fields needed to size the frame. It sits between the bit-timing/destuff stage and the error checkers, and returns to idle on any checker-reported error.

## Interface
Parameters:
- IFS_BITS, 3, intermission length in bits
- IDLE_RECESSIVE, 11, consecutive recessive bits required to leave error recovery

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- sp  input  1  sample-point strobe, one clk cycle wide
- rx_bit  input  1  sampled bus level at sp (0 = dominant)
- stuff_bit  input  1  current sampled bit is a stuff bit; qualified by sp
- err_in  input  1  any error checker flagged an error; sampled at sp
- field  output  4  current field code (field_t)
- bit_cnt  output  7  bit index within current field, 0-based
- eof_flag_n  output  1  low while in EOF field
- crc_flag_n  output  1  low while in CRC field
- ack_flag_n  output  1  low during ACK slot and ACK delimiter
- ide  output  1  captured IDE bit
- rtr  output  1  captured RTR bit
- dlc  output  4  captured DLC
- frame_done  output  1  one-cycle pulse when intermission completes

## Operation
- All state advances only on clk edges where sp=1. When sp=0, all state holds.
- From SOF through the end of CRC: if stuff_bit=1 at sp, the bit is ignored (no state or counter change). From CRC_DEL onward, stuff_bit is ignored.
- States and lengths:
  - IDLE: rx_bit=0 starts the frame → ID_A.
  - ID_A (11 bits) → RTR_SRR (1) → IDE (1).
  - IDE=0 (standard) → R0 (1) → DLC (4).
  - IDE=1 (extended) → ID_B (18) → RTR (1) → R1 (1) → R0 (1) → DLC (4).
  - After DLC: DATA (8·n bits) → CRC (15) → CRC_DEL (1) → ACK_SLOT (1) → ACK_DEL (1) → EOF (7) → IFS (IFS_BITS) → IDLE, with frame_done pulsed.
- Data byte count n:
  - n = 0 if rtr=1;
  - otherwise n = min(dlc, 8). DLC 9..15 gives 8 bytes.
  - If n=0, DATA is skipped and DLC goes straight to CRC.
- rtr is captured from the RTR_SRR bit in standard frames and from the RTR bit in extended frames. The SRR value is not checked.
- bit_cnt resets to 0 on every field transition and increments per consumed bit. The field exits when bit_cnt = length−1 at a consumed bit.
- Error handling: err_in=1 at sp in any state other than IDLE or ERR_WAIT → ERR_WAIT.
  - ERR_WAIT counts consecutive rx_bit=1; any 0 clears the count.
  - After IDLE_RECESSIVE recessive bits → IDLE, with no frame_done.
- Simultaneous events: err_in takes priority over a field transition on the same sp.
- A dominant bit during IFS is treated as an overload and also goes to ERR_WAIT.

## Timing
- All outputs are registered and reflect the new state one clk cycle after the sp cycle.
- Reset values:
  - field=IDLE, bit_cnt=0, dlc=0, ide=0, rtr=0, frame_done=0;
  - eof_flag_n=1, crc_flag_n=1, ack_flag_n=1.
- Flags are decoded from registered state, with no extra latency beyond state.
- eof_flag_n is low for exactly 7 consumed bits.
- Reset asserted mid-frame returns to IDLE immediately and asynchronously. The next dominant bit after reset release starts a new frame.

## Configuration
- CAN_EXT_ID_EN defined: extended frames are decoded as above.
- Not defined: ID_B, the extended RTR and R1 states are removed. IDE=1 at the IDE bit → ERR_WAIT, and ide output is tied to 0.

## Structure
- Package can_pkg holds:
  - field_t enum (IDLE, ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS, ERR_WAIT);
  - field length constants (ID_A_LEN=11, ID_B_LEN=18, DLC_LEN=4, CRC_LEN=15, EOF_LEN=7).
- One sub-module, can_field_len: combinational field-length lookup from field, dlc and rtr.

## Test plan
- Standard frame, ID 0x123, rtr=0, DLC=2, no stuff bits → DATA lasts 16 bits, crc_flag_n low 15 sp, eof_flag_n low 7 sp, frame_done pulses once after 3 IFS bits.
- Same frame with stuff_bit=1 on 3 bits inside ID_A → every field boundary is delayed by exactly 3 sp; stuff_bit=1 in EOF has no effect.
- Standard RTR frame with DLC=5 → DATA skipped, CRC follows DLC immediately; rtr=1, dlc=5.
- DLC=12 data frame → 64 data bits. Extended frame (CAN_EXT_ID_EN) → ide=1, ID_B of 18 bits; without the macro → ERR_WAIT at the IDE bit.
- err_in pulsed at bit 4 of DATA → ERR_WAIT. 10 recessive bits, 1 dominant, then 11 recessive → IDLE only after the last 11, with no frame_done.
- Reset asserted during CRC → field=IDLE and all flags 1 immediately. The next SOF decodes a full frame correctly.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types, field lengths and helper functions for the CAN field sequencer.
// Extended-frame decoding is enabled when CAN_EXT_ID_EN is defined.
package can_pkg;

  // Seventeen field codes need a 5-bit encoding.
  typedef enum logic [4:0] {
    IDLE, ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA,
    CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS, ERR_WAIT
  } field_t;

  localparam logic [6:0] ID_A_LEN = 7'd11;
  localparam logic [6:0] ID_B_LEN = 7'd18;
  localparam logic [6:0] DLC_LEN  = 7'd4;
  localparam logic [6:0] CRC_LEN  = 7'd15;
  localparam logic [6:0] EOF_LEN  = 7'd7;

  // Payload byte count: remote frames carry no data, DLC above 8 still means 8 bytes.
  function automatic logic [3:0] data_bytes(input logic [3:0] dlc, input logic rtr);
    if (rtr) return 4'd0;
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  // Stuff bits are only present from SOF through the end of the CRC sequence.
  function automatic logic in_stuff_region(input field_t f);
    return (f >= ID_A) && (f <= CRC);
  endfunction

  // Successor for fields whose exit does not depend on the received bit.
  function automatic field_t next_seq(input field_t f);
    case (f)
      ID_A:     return RTR_SRR;
      ID_B:     return RTR;
      RTR:      return R1;
      R1:       return R0;
      R0:       return DLC;
      DATA:     return CRC;
      CRC:      return CRC_DEL;
      CRC_DEL:  return ACK_SLOT;
      ACK_SLOT: return ACK_DEL;
      ACK_DEL:  return EOF;
      EOF:      return IFS;
      default:  return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/can_field_len.sv
// Combinational length lookup (in bits) for the current CAN frame field.
module can_field_len
  import can_pkg::*;
#(
  parameter int IFS_BITS = 3
) (
  input  field_t     field,
  input  logic [3:0] dlc,
  input  logic       rtr,
  output logic [6:0] len
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    len = 7'd1;
    case (field)
      ID_A:    len = ID_A_LEN;
      ID_B:    len = ID_B_LEN;
      DLC:     len = DLC_LEN;
      DATA:    len = {data_bytes(dlc, rtr), 3'b000};
      CRC:     len = CRC_LEN;
      EOF:     len = EOF_LEN;
      IFS:     len = 7'(IFS_BITS);
      default: len = 7'd1;
    endcase
  end

endmodule

// File: rtl/can_field_sequencer.sv
// CAN 2.0 frame-position tracker: advances on sample points, drives field windows.
// Extended identifiers are decoded only when CAN_EXT_ID_EN is defined.
module can_field_sequencer
  import can_pkg::*;
#(
  parameter int IFS_BITS       = 3,
  parameter int IDLE_RECESSIVE = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp,
  input  logic       rx_bit,
  input  logic       stuff_bit,
  input  logic       err_in,
  output field_t     field,
  output logic [6:0] bit_cnt,
  output logic       eof_flag_n,
  output logic       crc_flag_n,
  output logic       ack_flag_n,
  output logic       ide,
  output logic       rtr,
  output logic [3:0] dlc,
  output logic       frame_done
);

  localparam logic [6:0] REC_LAST = 7'(IDLE_RECESSIVE - 1);

  logic [6:0] len;
  logic       consume;
  logic       last;
  logic [3:0] dlc_next;

  can_field_len #(.IFS_BITS(IFS_BITS)) u_len (
    .field (field),
    .dlc   (dlc),
    .rtr   (rtr),
    .len   (len)
  );

  assign consume  = sp && !(stuff_bit && in_stuff_region(field));
  assign last     = (bit_cnt == len - 7'd1);
  // DLC arrives MSB first; the final bit completes the value used for the DATA decision.
  assign dlc_next = {dlc[2:0], rx_bit};

  // NOTE: reset is in the sensitivity list so it takes effect without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field      <= IDLE;
      bit_cnt    <= '0;
      rtr        <= 1'b0;
      dlc        <= '0;
      frame_done <= 1'b0;
`ifdef CAN_EXT_ID_EN
      ide        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments override the defaults.
      frame_done <= 1'b0;
      if (sp && err_in && field != IDLE && field != ERR_WAIT) begin
        field   <= ERR_WAIT;
        bit_cnt <= '0;
      end else if (consume) begin
        bit_cnt <= bit_cnt + 7'd1;
        case (field)
          IDLE: begin
            bit_cnt <= '0;
            if (!rx_bit) field <= ID_A;
          end
          RTR_SRR: begin
            rtr     <= rx_bit;
            field   <= IDE;
            bit_cnt <= '0;
          end
          IDE: begin
            bit_cnt <= '0;
`ifdef CAN_EXT_ID_EN
            ide   <= rx_bit;
            field <= rx_bit ? ID_B : R0;
`else
            field <= rx_bit ? ERR_WAIT : R0;
`endif
          end
`ifdef CAN_EXT_ID_EN
          RTR: begin
            rtr     <= rx_bit;
            field   <= R1;
            bit_cnt <= '0;
          end
`endif
          DLC: begin
            dlc <= dlc_next;
            if (last) begin
              bit_cnt <= '0;
              field   <= (data_bytes(dlc_next, rtr) == 4'd0) ? CRC : DATA;
            end
          end
          IFS: begin
            // A dominant bit in intermission is an overload condition.
            if (!rx_bit) begin
              field   <= ERR_WAIT;
              bit_cnt <= '0;
            end else if (last) begin
              field      <= IDLE;
              bit_cnt    <= '0;
              frame_done <= 1'b1;
            end
          end
          ERR_WAIT: begin
            if (!rx_bit) begin
              bit_cnt <= '0;
            end else if (bit_cnt == REC_LAST) begin
              field   <= IDLE;
              bit_cnt <= '0;
            end
          end
          default: begin
            if (last) begin
              field   <= next_seq(field);
              bit_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

`ifndef CAN_EXT_ID_EN
  assign ide = 1'b0;
`endif

  assign eof_flag_n = (field != EOF);
  assign crc_flag_n = (field != CRC);
  assign ack_flag_n = !((field == ACK_SLOT) || (field == ACK_DEL));

endmodule

// File: tb/tb_can_field_sequencer.sv
// Directed bench for can_field_sequencer: frame shapes, stuffing, errors and reset.
module tb_can_field_sequencer;
  import can_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sp;
  logic       rx_bit;
  logic       stuff_bit;
  logic       err_in;
  field_t     field;
  logic [6:0] bit_cnt;
  logic       eof_flag_n;
  logic       crc_flag_n;
  logic       ack_flag_n;
  logic       ide;
  logic       rtr;
  logic [3:0] dlc;
  logic       frame_done;

  can_field_sequencer #(.IFS_BITS(3), .IDLE_RECESSIVE(11)) dut (
    .clk        (clk),
    .reset      (reset),
    .sp         (sp),
    .rx_bit     (rx_bit),
    .stuff_bit  (stuff_bit),
    .err_in     (err_in),
    .field      (field),
    .bit_cnt    (bit_cnt),
    .eof_flag_n (eof_flag_n),
    .crc_flag_n (crc_flag_n),
    .ack_flag_n (ack_flag_n),
    .ide        (ide),
    .rtr        (rtr),
    .dlc        (dlc),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct packed {logic rx; logic stf;} tbit_t;
  tbit_t q[$];

  int k, crc_first, eof_first, done_k, bc_at5;
  int n_data, n_crc, n_eof, n_ack, n_done, n_idb;

  task automatic clear_stats();
    k = 0; crc_first = -1; eof_first = -1; done_k = -1; bc_at5 = -1;
    n_data = 0; n_crc = 0; n_eof = 0; n_ack = 0; n_done = 0; n_idb = 0;
  endtask

  // One sample point: sp high for one clock, then one idle clock before the next.
  task automatic tx(input logic rx, input logic stf, input logic err);
    @(negedge clk);
    sp = 1'b1; rx_bit = rx; stuff_bit = stf; err_in = err;
    @(negedge clk);
    sp = 1'b0; rx_bit = 1'b1; stuff_bit = 1'b0; err_in = 1'b0;
    if (field == DATA) n_data++;
    if (field == ID_B) n_idb++;
    if (!crc_flag_n) begin n_crc++; if (crc_first < 0) crc_first = k; end
    if (!eof_flag_n) begin n_eof++; if (eof_first < 0) eof_first = k; end
    if (!ack_flag_n) n_ack++;
    if (frame_done) begin n_done++; done_k = k; end
    if (k == 5) bc_at5 = int'(bit_cnt);
    k++;
  endtask

  task automatic push(input logic rx, input logic stf);
    q.push_back({rx, stf});
  endtask

  task automatic build_tail(input logic [3:0] dlc_v, input logic rtr_b, input logic eof_stuff);
    int n;
    n = rtr_b ? 0 : ((dlc_v > 4'd8) ? 8 : int'(dlc_v));
    for (int i = 3; i >= 0; i--) push(dlc_v[i], 1'b0);
    for (int i = 0; i < 8 * n; i++) push(i[0], 1'b0);
    for (int i = 0; i < 15; i++) push(i % 3 == 0, 1'b0);
    push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) push(1'b1, eof_stuff && i == 3);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0);
  endtask

  // Standard frame; nstuff stuff bits are inserted after the fourth identifier bit.
  task automatic build_std(input logic [10:0] id, input logic rtr_b, input logic [3:0] dlc_v,
                           input int nstuff, input logic eof_stuff);
    q.delete();
    push(1'b0, 1'b0);
    for (int i = 10; i >= 0; i--) begin
      push(id[i], 1'b0);
      if (i == 7) for (int s = 0; s < nstuff; s++) push(~id[i], 1'b1);
    end
    push(rtr_b, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
    build_tail(dlc_v, rtr_b, eof_stuff);
  endtask

  task automatic build_ext(input logic [3:0] dlc_v);
    q.delete();
    push(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) push(i[0], 1'b0);
    push(1'b1, 1'b0); push(1'b1, 1'b0);
    for (int i = 0; i < 18; i++) push(i[1], 1'b0);
    push(1'b0, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
    build_tail(dlc_v, 1'b0, 1'b0);
  endtask

  task automatic run_q();
    foreach (q[i]) tx(q[i].rx, q[i].stf, 1'b0);
    tx(1'b1, 1'b0, 1'b0);
    tx(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic hit;
    reset = 1'b1; sp = 1'b0; rx_bit = 1'b1; stuff_bit = 1'b0; err_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_field", field, IDLE);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_dlc", dlc, 0);
    check("rst_ide", ide, 0);
    check("rst_rtr", rtr, 0);
    check("rst_done", frame_done, 0);
    check("rst_flags", {eof_flag_n, crc_flag_n, ack_flag_n}, 3'b111);
    reset = 1'b0;

    // Standard data frame, ID 0x123, DLC 2.
    build_std(11'h123, 1'b0, 4'd2, 0, 1'b0); clear_stats(); run_q();
    check("std_bitcnt5", bc_at5, 5);
    check("std_data_bits", n_data, 16);
    check("std_crc_bits", n_crc, 15);
    check("std_crc_start", crc_first, 34);
    check("std_ack_bits", n_ack, 2);
    check("std_eof_bits", n_eof, 7);
    check("std_eof_start", eof_first, 52);
    check("std_done_cnt", n_done, 1);
    check("std_done_at", done_k, 62);
    check("std_dlc", dlc, 2);
    check("std_rtr", rtr, 0);
    check("std_ide", ide, 0);
    check("std_field_end", field, IDLE);

    // Three stuff bits in ID_A shift every boundary by 3; a stuff flag in EOF is ignored.
    build_std(11'h123, 1'b0, 4'd2, 3, 1'b1); clear_stats(); run_q();
    check("stf_bitcnt5", bc_at5, 4);
    check("stf_crc_start", crc_first, 37);
    check("stf_crc_bits", n_crc, 15);
    check("stf_eof_start", eof_first, 55);
    check("stf_eof_bits", n_eof, 7);
    check("stf_done_at", done_k, 65);
    check("stf_done_cnt", n_done, 1);

    // Remote frame with DLC 5: no DATA field.
    build_std(11'h7ff, 1'b1, 4'd5, 0, 1'b0); clear_stats(); run_q();
    check("rtr_data_bits", n_data, 0);
    check("rtr_crc_start", crc_first, 18);
    check("rtr_rtr", rtr, 1);
    check("rtr_dlc", dlc, 5);
    check("rtr_done_at", done_k, 46);

    // DLC 12 clamps to 8 bytes.
    build_std(11'h055, 1'b0, 4'd12, 0, 1'b0); clear_stats(); run_q();
    check("dlc12_data_bits", n_data, 64);
    check("dlc12_crc_start", crc_first, 82);
    check("dlc12_dlc", dlc, 12);
    check("dlc12_done_at", done_k, 110);

    // Extended frame.
    build_ext(4'd1); clear_stats();
`ifdef CAN_EXT_ID_EN
    run_q();
    check("ext_ide", ide, 1);
    check("ext_idb_bits", n_idb, 18);
    check("ext_data_bits", n_data, 8);
    check("ext_crc_start", crc_first, 46);
    check("ext_done_cnt", n_done, 1);
`else
    for (int i = 0; i < 14; i++) tx(q[i].rx, q[i].stf, 1'b0);
    check("ext_off_field", field, ERR_WAIT);
    check("ext_off_ide", ide, 0);
    repeat (11) tx(1'b1, 1'b0, 1'b0);
    check("ext_off_recover", field, IDLE);
    check("ext_off_done", n_done, 0);
`endif

    // Error at DATA bit 4, then recovery needing 11 consecutive recessive bits.
    build_std(11'h123, 1'b0, 4'd2, 0, 1'b0); clear_stats(); hit = 1'b0;
    for (int i = 0; i < q.size() && !hit; i++) begin
      if (field == DATA && bit_cnt == 7'd4) begin
        tx(q[i].rx, 1'b0, 1'b1);
        hit = 1'b1;
      end else begin
        tx(q[i].rx, q[i].stf, 1'b0);
      end
    end
    check("err_reached_data4", hit, 1);
    check("err_field", field, ERR_WAIT);
    repeat (10) tx(1'b1, 1'b0, 1'b0);
    check("err_after10_field", field, ERR_WAIT);
    check("err_after10_cnt", bit_cnt, 10);
    tx(1'b0, 1'b0, 1'b0);
    check("err_dominant_cnt", bit_cnt, 0);
    repeat (10) tx(1'b1, 1'b0, 1'b0);
    check("err_after_10_more", field, ERR_WAIT);
    tx(1'b1, 1'b0, 1'b0);
    check("err_recovered", field, IDLE);
    check("err_no_done", n_done, 0);

    // Asynchronous reset during CRC, then a clean frame.
    build_std(11'h123, 1'b0, 4'd2, 0, 1'b0); clear_stats(); hit = 1'b0;
    for (int i = 0; i < q.size() && !hit; i++) begin
      tx(q[i].rx, q[i].stf, 1'b0);
      if (field == CRC) hit = 1'b1;
    end
    check("rstcrc_reached", hit, 1);
    #2 reset = 1'b1;
    #1;
    check("rstcrc_field", field, IDLE);
    check("rstcrc_cnt", bit_cnt, 0);
    check("rstcrc_flags", {eof_flag_n, crc_flag_n, ack_flag_n}, 3'b111);
    @(negedge clk);
    reset = 1'b0;
    build_std(11'h123, 1'b0, 4'd2, 0, 1'b0); clear_stats(); run_q();
    check("post_rst_data", n_data, 16);
    check("post_rst_crc_start", crc_first, 34);
    check("post_rst_done_at", done_k, 62);
    check("post_rst_done_cnt", n_done, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
